// File: rtl/msh_wr_inq.sv
// msh_wr_inq: in-order write request queue for the mesh memory banks.
// Requests are buffered in a DEPTH-entry FIFO. The head entry is issued to
// the write datapath when its target bank has credit. A head that lacks
// credit blocks every entry behind it.
//
// Ports:
//   mclk, mrst_n                          clock, async active-low reset
//   i_req_valid/o_req_ready               upstream request handshake
//   i_req_addr/i_req_data                 request payload; bank = addr LSBs
//   o_wr_valid/o_wr_bank/addr/data        registered one-cycle write issue
//   i_crd_rtn                             per-bank credit return pulses
//   o_crd_err                             sticky credit-overflow flag
//   o_occ                                 FIFO occupancy
module msh_wr_inq #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned CREDITS   = 2
) (
  input  logic                         mclk,
  input  logic                         mrst_n,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDR_W-1:0]            i_req_addr,
  input  logic [DATA_W-1:0]            i_req_data,
  output logic                         o_wr_valid,
  output logic [$clog2(NUM_BANKS)-1:0] o_wr_bank,
  output logic [ADDR_W-1:0]            o_wr_addr,
  output logic [DATA_W-1:0]            o_wr_data,
  input  logic [NUM_BANKS-1:0]         i_crd_rtn,
  output logic                         o_crd_err,
  output logic [$clog2(DEPTH):0]       o_occ
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned BW = $clog2(NUM_BANKS);
  localparam int unsigned CW = 3;

  // FIFO storage (no reset needed: validity is tracked by the pointers)
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] occ_q;

  logic [CW-1:0] crd     [NUM_BANKS];
  logic [CW-1:0] crd_nxt [NUM_BANKS];
  logic          err_set_c;

  logic          push_c;
  logic          empty_c;
  logic          issue_c;
  logic [AW-1:0] rd_idx_c;
  logic [BW-1:0] head_bank_c;

  // Handshake and head-of-line issue decision
  assign o_req_ready = (occ_q < PW'(DEPTH));
  assign push_c      = i_req_valid & o_req_ready;
  assign empty_c     = (wr_ptr == rd_ptr);
  assign rd_idx_c    = rd_ptr[AW-1:0];
  assign head_bank_c = addr_mem[rd_idx_c][BW-1:0];
  assign issue_c     = !empty_c && (crd[head_bank_c] != '0);
  assign o_occ       = occ_q;

  // Entry write
  always_ff @(posedge mclk) begin
    if (push_c) begin
      addr_mem[wr_ptr[AW-1:0]] <= i_req_addr;
      data_mem[wr_ptr[AW-1:0]] <= i_req_data;
    end
  end

  // Pointers and occupancy; pointers wrap modulo 2*DEPTH
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= '0;
    end else begin
      if (push_c)  wr_ptr <= wr_ptr + PW'(1);
      if (issue_c) rd_ptr <= rd_ptr + PW'(1);
      occ_q <= occ_q + PW'(push_c) - PW'(issue_c);
    end
  end

  // Registered issue; payload holds its last value while idle
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      o_wr_valid <= 1'b0;
      o_wr_bank  <= '0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
    end else begin
      o_wr_valid <= issue_c;
      if (issue_c) begin
        o_wr_bank <= head_bank_c;
        o_wr_addr <= addr_mem[rd_idx_c];
        o_wr_data <= data_mem[rd_idx_c];
      end
    end
  end

  // Credit update: issue and return in the same cycle cancel; a return to a
  // full counter saturates and flags overflow
  always_comb begin
    err_set_c = 1'b0;
    for (int b = 0; b < int'(NUM_BANKS); b++) begin
      crd_nxt[b] = crd[b];
      if (issue_c && (head_bank_c == BW'(b)) && !i_crd_rtn[b]) begin
        crd_nxt[b] = crd[b] - CW'(1);
      end else if (i_crd_rtn[b] && !(issue_c && (head_bank_c == BW'(b)))) begin
        if (crd[b] == CW'(CREDITS)) begin
          err_set_c = 1'b1;
        end else begin
          crd_nxt[b] = crd[b] + CW'(1);
        end
      end
    end
  end

  // Credit counters and sticky error
  always_ff @(posedge mclk or negedge mrst_n) begin
    if (!mrst_n) begin
      for (int b = 0; b < int'(NUM_BANKS); b++) crd[b] <= CW'(CREDITS);
      o_crd_err <= 1'b0;
    end else begin
      for (int b = 0; b < int'(NUM_BANKS); b++) crd[b] <= crd_nxt[b];
      if (err_set_c) o_crd_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_msh_wr_inq.sv
// Directed bench for msh_wr_inq with default parameters.
module tb_msh_wr_inq;

  logic        mclk = 1'b0;
  logic        mrst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [15:0] i_req_addr;
  logic [63:0] i_req_data;
  logic        o_wr_valid;
  logic [1:0]  o_wr_bank;
  logic [15:0] o_wr_addr;
  logic [63:0] o_wr_data;
  logic [3:0]  i_crd_rtn;
  logic        o_crd_err;
  logic [2:0]  o_occ;

  int passed = 0;
  int total  = 0;

  msh_wr_inq dut (
    .mclk        (mclk),
    .mrst_n      (mrst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_wr_valid  (o_wr_valid),
    .o_wr_bank   (o_wr_bank),
    .o_wr_addr   (o_wr_addr),
    .o_wr_data   (o_wr_data),
    .i_crd_rtn   (i_crd_rtn),
    .o_crd_err   (o_crd_err),
    .o_occ       (o_occ)
  );

  always #5 mclk = ~mclk;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic req(input logic [15:0] a, input logic [63:0] d);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_data  = d;
  endtask

  task automatic idle();
    i_req_valid = 1'b0;
  endtask

  // Checks an issued write: valid, bank, address, data
  task automatic chk_issue(input string tag, input logic [15:0] a, input logic [63:0] d);
    chk({tag, ".valid"}, 64'(o_wr_valid), 64'd1);
    chk({tag, ".bank"},  64'(o_wr_bank),  64'(a[1:0]));
    chk({tag, ".addr"},  64'(o_wr_addr),  64'(a));
    chk({tag, ".data"},  o_wr_data,       d);
  endtask

  initial begin
    mrst_n      = 1'b0;
    i_req_valid = 1'b0;
    i_req_addr  = '0;
    i_req_data  = '0;
    i_crd_rtn   = '0;
    tick();
    tick();
    chk("rst.occ",   64'(o_occ),       64'd0);
    chk("rst.ready", 64'(o_req_ready), 64'd1);
    chk("rst.valid", 64'(o_wr_valid),  64'd0);
    chk("rst.err",   64'(o_crd_err),   64'd0);
    chk("rst.addr",  64'(o_wr_addr),   64'd0);
    mrst_n = 1'b1;
    tick();

    // Single push, two-cycle latency to bank 1
    req(16'h0005, 64'hA5);
    tick();
    idle();
    chk("t1.occ1",   64'(o_occ),      64'd1);
    chk("t1.nobyp",  64'(o_wr_valid), 64'd0);
    tick();
    chk_issue("t1.iss", 16'h0005, 64'hA5);
    chk("t1.occ0",   64'(o_occ),      64'd0);
    tick();
    chk("t1.pulse",  64'(o_wr_valid), 64'd0);
    chk("t1.hold",   64'(o_wr_addr),  64'h0005);

    // Bank 2 stream with two credits: two issue, the rest back up
    req(16'h0012, 64'h100); tick();
    req(16'h0022, 64'h101); tick();
    chk_issue("t2.i0", 16'h0012, 64'h100);
    req(16'h0032, 64'h102); tick();
    chk_issue("t2.i1", 16'h0022, 64'h101);
    req(16'h0042, 64'h103); tick();
    chk("t2.stall", 64'(o_wr_valid), 64'd0);
    req(16'h0052, 64'h104); tick();
    chk("t2.occ3",  64'(o_occ),       64'd3);
    chk("t2.rdy3",  64'(o_req_ready), 64'd1);
    req(16'h0062, 64'h105); tick();
    chk("t2.occ4",  64'(o_occ),       64'd4);
    chk("t2.rdy4",  64'(o_req_ready), 64'd0);
    req(16'h0072, 64'h106); tick();
    chk("t2.held",  64'(o_occ),       64'd4);
    // Credit returned while full and push held: used one cycle later
    i_crd_rtn = 4'b0100; tick();
    i_crd_rtn = 4'b0000;
    chk("t2.noearly", 64'(o_wr_valid), 64'd0);
    chk("t2.occ4b",   64'(o_occ),      64'd4);
    tick();
    chk_issue("t2.i2", 16'h0032, 64'h102);
    chk("t2.occpop", 64'(o_occ),       64'd3);
    chk("t2.rdyon",  64'(o_req_ready), 64'd1);
    tick();
    idle();
    chk("t2.pushed", 64'(o_occ),       64'd4);
    chk("t2.one",    64'(o_wr_valid),  64'd0);
    // Drain, checking order; a return and an issue in one cycle cancel
    i_crd_rtn = 4'b0100; tick();
    tick();
    chk_issue("t2.i3", 16'h0042, 64'h103);
    i_crd_rtn = 4'b0000; tick();
    chk_issue("t2.i4", 16'h0052, 64'h104);
    tick();
    chk("t2.dry",    64'(o_wr_valid), 64'd0);
    chk("t2.occ2",   64'(o_occ),      64'd2);
    i_crd_rtn = 4'b0100; tick();
    tick();
    chk_issue("t2.i5", 16'h0062, 64'h105);
    i_crd_rtn = 4'b0000; tick();
    chk_issue("t2.i6", 16'h0072, 64'h106);
    chk("t2.empty",  64'(o_occ),      64'd0);
    i_crd_rtn = 4'b0100; tick();
    tick();
    i_crd_rtn = 4'b0000;
    chk("t2.noerr",  64'(o_crd_err),  64'd0);

    // Head-of-line block: bank 0 starved, bank 1 entry waits behind it
    req(16'h0010, 64'h200); tick();
    req(16'h0020, 64'h201); tick();
    req(16'h0030, 64'h202); tick();
    req(16'h0041, 64'h203); tick();
    idle();
    tick();
    tick();
    chk("t3.block",  64'(o_wr_valid), 64'd0);
    chk("t3.occ2",   64'(o_occ),      64'd2);
    i_crd_rtn = 4'b0001; tick();
    i_crd_rtn = 4'b0000;
    chk("t3.wait",   64'(o_wr_valid), 64'd0);
    tick();
    chk_issue("t3.b0", 16'h0030, 64'h202);
    tick();
    chk_issue("t3.b1", 16'h0041, 64'h203);
    i_crd_rtn = 4'b0011; tick();
    i_crd_rtn = 4'b0001; tick();
    i_crd_rtn = 4'b0000;
    chk("t3.noerr",  64'(o_crd_err),  64'd0);

    // Overflow: return to a full bank-0 counter
    i_crd_rtn = 4'b0001; tick();
    i_crd_rtn = 4'b0000;
    chk("t4.err",    64'(o_crd_err),  64'd1);
    tick();
    tick();
    chk("t4.sticky", 64'(o_crd_err),  64'd1);
    // Counter saturated at 2: only two of three bank-0 writes issue
    req(16'h0050, 64'h300); tick();
    req(16'h0060, 64'h301); tick();
    chk_issue("t4.i0", 16'h0050, 64'h300);
    req(16'h0070, 64'h302); tick();
    chk_issue("t4.i1", 16'h0060, 64'h301);
    req(16'h0080, 64'h303); tick();
    chk("t4.sat",    64'(o_wr_valid), 64'd0);
    req(16'h0090, 64'h304); tick();
    idle();
    chk("t5.occ3",   64'(o_occ),      64'd3);

    // Asynchronous reset mid-cycle with entries queued
    #2;
    mrst_n = 1'b0;
    #1;
    chk("t5.occ",    64'(o_occ),       64'd0);
    chk("t5.ready",  64'(o_req_ready), 64'd1);
    chk("t5.valid",  64'(o_wr_valid),  64'd0);
    chk("t5.err",    64'(o_crd_err),   64'd0);
    chk("t5.addr",   64'(o_wr_addr),   64'd0);
    chk("t5.data",   64'(o_wr_data),   64'd0);
    tick();
    mrst_n = 1'b1;
    tick();
    chk("t5.quiet1", 64'(o_wr_valid), 64'd0);
    tick();
    chk("t5.quiet2", 64'(o_wr_valid), 64'd0);
    chk("t5.occz",   64'(o_occ),      64'd0);
    // Credits restored: a bank-0 write issues again
    req(16'h00A0, 64'h400); tick();
    idle();
    tick();
    chk_issue("t5.iss", 16'h00A0, 64'h400);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
